// File: rtl/instruction_fetch.sv
// RV32I instruction fetch stage: PC register, ROM word addressing, IF/ID register and fetch counter.
// Optional FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          ROM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_fetch,
  input  logic                      flush_decode,
  input  logic                      pc_redirect_valid,
  input  logic [31:0]               pc_redirect_target,
  output logic [ROM_ADDR_WIDTH-1:0] instruction_memory_address,
  input  logic [31:0]               instruction_memory_data,
  output logic [31:0]               fetch_pc,
  output logic [31:0]               if_id_instruction,
  output logic [31:0]               if_id_pc,
  output logic [31:0]               if_id_pc_plus4,
  output logic                      if_id_valid,
  output logic [31:0]               instructions_fetched,
  output logic                      fetch_misaligned_error
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_pc4_reg, id_pc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] count_reg, count_next;
  logic        load_fetch;

  assign pc_plus4 = pc_reg + 32'd4;

  // Priority: redirect > flush > stall > normal fetch.
  always_comb begin
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    id_pc_next  = id_pc_reg;
    id_pc4_next = id_pc4_reg;
    valid_next  = valid_reg;
    load_fetch  = 1'b0;
    if (pc_redirect_valid) begin
      pc_next     = {pc_redirect_target[31:2], 2'b00};
      instr_next  = NOP_INSTR;
      id_pc_next  = 32'd0;
      id_pc4_next = 32'd4;
      valid_next  = 1'b0;
    end else if (flush_decode) begin
      if (!stall_fetch) begin
        pc_next = pc_plus4;
      end
      instr_next  = NOP_INSTR;
      id_pc_next  = 32'd0;
      id_pc4_next = 32'd4;
      valid_next  = 1'b0;
    end else if (!stall_fetch) begin
      pc_next     = pc_plus4;
      instr_next  = instruction_memory_data;
      id_pc_next  = pc_reg;
      id_pc4_next = pc_plus4;
      valid_next  = 1'b1;
      load_fetch  = 1'b1;
    end
  end

  // Counter wraps naturally at 2^32.
  assign count_next = load_fetch ? count_reg + 32'd1 : count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg     <= RESET_PC;
      instr_reg  <= NOP_INSTR;
      id_pc_reg  <= 32'd0;
      id_pc4_reg <= 32'd4;
      valid_reg  <= 1'b0;
      count_reg  <= 32'd0;
    end else begin
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      id_pc_reg  <= id_pc_next;
      id_pc4_reg <= id_pc4_next;
      valid_reg  <= valid_next;
      count_reg  <= count_next;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_reg, mis_next;

  assign mis_next = mis_reg | (pc_redirect_valid & (pc_redirect_target[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_reg <= 1'b0;
    end else begin
      mis_reg <= mis_next;
    end
  end

  assign fetch_misaligned_error = mis_reg;
`else
  assign fetch_misaligned_error = 1'b0;
`endif

  // PCs beyond the ROM span alias onto it through the truncated slice.
  assign instruction_memory_address = pc_reg[ROM_ADDR_WIDTH+1:2];
  assign fetch_pc                   = pc_reg;
  assign if_id_instruction          = instr_reg;
  assign if_id_pc                   = id_pc_reg;
  assign if_id_pc_plus4             = id_pc4_reg;
  assign if_id_valid                = valid_reg;
  assign instructions_fetched       = count_reg;

endmodule
